// File: rtl/i_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package i_fetch_stage_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   localparam logic [5:0]  HALT_OP_DEFAULT = 6'h3F;
   localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
   localparam logic [31:0] PC_INCR         = 32'd4;

endpackage : i_fetch_stage_pkg

// File: rtl/i_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures the fetched instruction and its PC+4,
// with hold (stall), flush (redirect) and bubble insertion (halted fetch).
module if_id_reg
   import i_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n_i,
   input  logic        hold_i,
   input  logic        flush_i,
   input  logic        load_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;

   // Flush beats hold; pc4 is left untouched by both flush and bubbles.
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!hold_i) begin
         if (load_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule : if_id_reg

// File: rtl/i_fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT control and delivered-
// instruction counter, feeding an IF/ID register toward decode.
module i_fetch_stage
   import i_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [5:0]  HALT_OP  = HALT_OP_DEFAULT
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_addr,
   output logic [31:0] instr_addr,
   input  logic [31:0] instr_in,
   output logic [31:0] instr_out,
   output logic [31:0] pc4_out,
   output logic        valid_out,
   output logic        halted,
   output logic [31:0] fetch_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  fetch_count_q, fetch_count_d;
   logic [31:0]  pc_plus4;
   logic         fetch_fire;
   logic         is_halt_op;

   assign pc_plus4   = pc_q + PC_INCR;
   assign is_halt_op = (instr_in[31:26] == HALT_OP);
   assign fetch_fire = !redirect && !stall && (state_q == RUN);

   // Priority: redirect, then stall, then halt detection.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_count_d = fetch_count_q;
      if (redirect) begin
         pc_d    = redirect_addr & ~32'd3;
         state_d = RUN;
      end else if (fetch_fire) begin
         fetch_count_d = fetch_count_q + 32'd1;
         if (is_halt_op) begin
            state_d = HALT;
         end else begin
            pc_d = pc_plus4;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         fetch_count_q <= 32'h0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk     (clk),
      .rst_n_i (rst_n),
      .hold_i  (stall),
      .flush_i (redirect),
      .load_i  (state_q == RUN),
      .instr_i (instr_in),
      .pc4_i   (pc_plus4),
      .instr_o (instr_out),
      .pc4_o   (pc4_out),
      .valid_o (valid_out)
   );

   assign instr_addr  = pc_q;
   assign halted      = (state_q == HALT);
   assign fetch_count = fetch_count_q;

endmodule : i_fetch_stage

// File: doc/i_fetch_stage.md
I_FETCH_STAGE -- requirements
Module: i_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter HALT_OP, default 6'h3F, is the opcode (instr[31:26]) that halts fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 stall  input  1  hold PC and IF/ID outputs this cycle.
REQ-006 redirect  input  1  load PC from redirect_addr and flush IF/ID.
REQ-007 redirect_addr  input  32  new fetch address (branch/jump target).
REQ-008 instr_addr  output  32  address to combinational instruction memory; equals PC.
REQ-009 instr_in  input  32  instruction-memory read data for instr_addr, same cycle.
REQ-010 instr_out  output  32  registered instruction to decode stage.
REQ-011 pc4_out  output  32  registered PC+4 of instr_out.
REQ-012 valid_out  output  1  instr_out holds a real instruction; 0 = bubble.
REQ-013 halted  output  1  fetch is in the HALT state.
REQ-014 fetch_count  output  32  number of valid instructions delivered.

Function
REQ-015 instr_addr SHALL equal the PC register combinationally; there is no added latency between PC and the memory address.
REQ-016 The fetch latency SHALL be one cycle: the instruction at PC appears on instr_out on the next rising edge.
REQ-017 The FSM SHALL have two states, RUN and HALT, and SHALL enter RUN on reset.
REQ-018 In RUN with stall=0 and redirect=0:
- PC <= PC+4.
- instr_out <= instr_in.
- pc4_out <= PC+4.
- valid_out <= 1.
REQ-019 PC arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 32'h0.
REQ-020 With stall=1 and redirect=0, PC, instr_out, pc4_out, valid_out and fetch_count SHALL hold their values, in both RUN and HALT.
REQ-021 Redirect SHALL take priority over stall and over halt detection; when redirect=1 in any state:
- PC <= {redirect_addr[31:2], 2'b00}.
- instr_out <= 0, valid_out <= 0.
- pc4_out holds.
- FSM goes to RUN.
REQ-022 In RUN with stall=0, redirect=0 and instr_in[31:26]==HALT_OP:
- the halt instruction is delivered per REQ-018.
- PC holds (it does not advance).
- FSM goes to HALT.
REQ-023 In HALT with stall=0 and redirect=0:
- PC holds.
- instr_out <= 0, valid_out <= 0.
REQ-024 halted SHALL be 1 exactly while the FSM is in HALT.
REQ-025 fetch_count SHALL increment by 1 on every edge that writes valid_out <= 1, and SHALL wrap modulo 2^32.
REQ-026 stall, redirect and halt occurring in the same cycle SHALL resolve in this priority order: rst_n low, then redirect, then stall, then halt.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL load:
- PC = RESET_PC.
- instr_out = 0, pc4_out = 0, valid_out = 0.
- fetch_count = 0.
- FSM = RUN (halted = 0).
REQ-028 Reset SHALL override stall and redirect, and SHALL abort any operation in progress with no partial update.
REQ-029 The first valid instruction after reset deassertion SHALL be the one at RESET_PC, appearing one cycle later.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state typedef (RUN, HALT).
- the HALT_OP default.
- the NOP/bubble constant 32'h0.
- the PC increment constant 32'd4.
REQ-031 The IF/ID output register group (instr_out, pc4_out, valid_out with hold and flush) SHALL be one sub-module, if_id_reg.
REQ-032 The PC register, FSM and fetch counter SHALL reside in the top of i_fetch_stage.

Verification
REQ-033 Reset then run 4 cycles with RESET_PC=0 and no stall -> instr_addr = 0, 4, 8, 12; valid_out=1 from cycle 1; fetch_count=4.
REQ-034 Stall held 3 cycles at PC=8 -> instr_addr stays 8; instr_out, pc4_out=8 and fetch_count unchanged; sequence resumes with PC=12.
REQ-035 redirect=1 with redirect_addr=32'h0000_0043 and stall=1 in the same cycle -> next PC=32'h40, valid_out=0, instr_out=0; next cycle delivers the instruction at 32'h40 with pc4_out=32'h44.
REQ-036 Instruction with opcode 6'h3F fetched at PC=16 -> delivered with pc4_out=20, halted=1, PC stays 16, following cycles valid_out=0; a later redirect to 32'h100 clears halted.
REQ-037 RESET_PC=32'hFFFF_FFFC, run 2 cycles -> instr_addr = FFFF_FFFC, then 0.
REQ-038 rst_n=0 mid-stream while a redirect is asserted -> PC=RESET_PC, valid_out=0, fetch_count=0, halted=0 on that edge.
